multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the RV32I datapath; replaces single-cycle timing with a FETCH/DECODE/EXECUTE/MEM/WB state machine.
- The existing combinational decoder still produces the static fields (ALUOp, ImmSrc, BrOp, DMCtrl, data sources).
- This block only produces per-state write enables, memory handshake and address-select timing.
- It sits between the decoder, the shared instruction/data memory port and the PC/IR/register-file write strobes.

Parameters:
- TIMEOUT_CYCLES, 16: max wait cycles for mem_ready before fault; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- opcode  in  7  instruction opcode, from the IR
- dec_ru_wr  in  1  decoder register-write request
- dec_dm_wr  in  1  decoder store request
- branch_taken  in  1  branch unit result, valid in EXECUTE
- mem_ready  in  1  memory port completes the transfer this cycle
- mem_req  out  1  memory transfer request
- mem_iord  out  1  address select: 1 = PC (fetch), 0 = ALU result (data)
- ir_wr  out  1  IR load strobe
- pc_wr  out  1  PC update strobe
- pc_src  out  1  0 = PC+4, 1 = branch/jump target
- ru_wr  out  1  gated register-file write
- dm_wr  out  1  gated data-memory write
- state_o  out  3  current state, debug
- fault  out  1  sticky fault flag
- cycle_cnt  out  CNT_W  cycle counter (optional feature)
- instret_cnt  out  CNT_W  retired-instruction counter (optional feature)

Behaviour:
- Reset: when rst is high at a clk edge:
  - state goes to FETCH, fault=0, wait counter=0, counters=0.
  - All strobes are combinational from state; in FETCH mem_req=1 and mem_iord=1, all other strobes 0.
- Memory handshake:
  - mem_req is held high until a cycle where mem_ready=1; the transfer completes in that cycle.
  - mem_ready while mem_req=0 is ignored.
- FETCH: mem_req=1, mem_iord=1. On mem_ready: ir_wr=1 and go to DECODE; otherwise stay.
- DECODE: one cycle, no strobes.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} goes to FAULT.
  - All legal opcodes go to EXECUTE.
- EXECUTE:
  - Branch (1100011): pc_wr=1, pc_src=branch_taken, then FETCH. Retires; 3 cycles at zero wait.
  - Load or store: go to MEM.
  - All others: go to WB.
- MEM: mem_req=1, mem_iord=0, dm_wr=dec_dm_wr.
  - The store holds dm_wr with mem_req until mem_ready. On ready: pc_wr=1, pc_src=0, then FETCH (4 cycles at zero wait).
  - A load goes to WB on mem_ready.
- WB: ru_wr=dec_ru_wr, pc_wr=1, then FETCH.
  - pc_src=1 for 1101111/1100111, else 0.
  - ALU instructions take 4 cycles, loads 5 cycles at zero wait.
- Gating: ru_wr is asserted only in WB; dm_wr only in MEM. Decoder requests in any other state are masked.
- Timeout:
  - The wait counter increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0, and clears on completion.
  - When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, the next state is FAULT.
  - mem_ready arriving in that same cycle wins: the transfer completes and there is no fault.
- FAULT: fault=1, all strobes 0, absorbing; only rst exits.
- Reset mid-operation: any in-flight transfer is abandoned; mem_req is still 1 in the FETCH reset state, so memory must tolerate a restarted request.
- state_o encoding, fixed: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, FAULT=7.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle not in FAULT.
  - instret_cnt increments on every cycle with pc_wr=1.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: the ports remain and are driven to constant 0; no counter flops are instantiated.

Decomposition:
- Shared package multicycle_pkg holds:
  - state_t enum with the fixed encodings above.
  - Opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
- One sub-module, mem_wait_timer: wait counter plus timeout compare, parameterised by TIMEOUT_CYCLES.

Test Plan:
- R-type: opcode=0110011, mem_ready tied 1 → states 0,1,2,4,0; ir_wr in cycle 1, ru_wr and pc_wr in cycle 4 only, pc_src=0.
- Load with memory waits: opcode=0000011, mem_ready=0 for 3 MEM cycles → MEM held 4 cycles with mem_req=1, mem_iord=0; WB then ru_wr=1.
- Branch: opcode=1100011, branch_taken=1 → pc_wr=1 and pc_src=1 in EXECUTE, ru_wr and dm_wr never 1; 3 cycles total.
- Illegal opcode: opcode=1111111 → DECODE→FAULT, fault=1, all strobes stay 0 for 20 cycles; rst pulse returns state_o=0, fault=0.
- Timeout: TIMEOUT_CYCLES=4, mem_ready=0 in FETCH → FAULT after 4 wait cycles. A rerun with mem_ready=1 on the 4th wait cycle → DECODE, no fault.
- Perf counters (MULTICYCLE_PERF_CNT_EN): 10 back-to-back R-type at zero wait → instret_cnt=10, cycle_cnt=40. Mid-store reset → both counters 0, state_o=0, no dm_wr after reset.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multicycle RV32I control sequencer.
// Holds the fixed state encoding, the opcode constants and an opcode legality helper.
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_FAULT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // True for the nine RV32I base opcodes this sequencer can execute.
    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Decoder inputs, shared memory handshake and write strobes of the sequencer.
// master: the sequencer side; slave: the datapath / memory side.
interface multicycle_control_fsm_if;

    logic [6:0] opcode;
    logic       dec_ru_wr;
    logic       dec_dm_wr;
    logic       branch_taken;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_iord;
    logic       ir_wr;
    logic       pc_wr;
    logic       pc_src;
    logic       ru_wr;
    logic       dm_wr;

    modport master (
        input  opcode, dec_ru_wr, dec_dm_wr, branch_taken, mem_ready,
        output mem_req, mem_iord, ir_wr, pc_wr, pc_src, ru_wr, dm_wr
    );

    modport slave (
        output opcode, dec_ru_wr, dec_dm_wr, branch_taken, mem_ready,
        input  mem_req, mem_iord, ir_wr, pc_wr, pc_src, ru_wr, dm_wr
    );

endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait counter with timeout compare.
// Counts consecutive cycles in which a transfer is requested but not completed;
// timeout_o flags the cycle in which the TIMEOUT_CYCLES-th wait happens.
// TIMEOUT_CYCLES = 0 disables the timeout entirely.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting_i,
    output logic timeout_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: advance while waiting (saturating at LAST), clear otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (waiting_i) begin
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Timeout fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
    always_comb begin
        timeout_o = 1'b0;
        if (TIMEOUT_CYCLES == 0) begin
            timeout_o = 1'b0;
        end else begin
            timeout_o = waiting_i && (cnt_q == LAST);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a
// sticky FAULT state for illegal opcodes and memory timeouts.
// Strobes are decoded combinationally from the current state (plus mem_ready
// and the decoder requests), so they line up with the cycle they act in.
// Optional feature macro: MULTICYCLE_PERF_CNT_EN enables the cycle and
// retired-instruction counters; without it both outputs are tied to 0.
module multicycle_control_fsm
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.master bus,
    output logic [2:0]               state_o,
    output logic                     fault,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         instret_cnt
);

    state_t state_q;
    state_t state_d;

    logic   mem_req_s;
    logic   mem_iord_s;
    logic   ir_wr_s;
    logic   pc_wr_s;
    logic   pc_src_s;
    logic   ru_wr_s;
    logic   dm_wr_s;
    logic   waiting_s;
    logic   timeout_s;

    // Waiting is derived from the state directly to keep the timer out of the FSM's combinational loop.
    assign waiting_s = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .waiting_i (waiting_s),
        .timeout_o (timeout_s)
    );

    // Next-state and per-state strobe decode; everything defaults to idle.
    always_comb begin
        state_d    = state_q;
        mem_req_s  = 1'b0;
        mem_iord_s = 1'b0;
        ir_wr_s    = 1'b0;
        pc_wr_s    = 1'b0;
        pc_src_s   = 1'b0;
        ru_wr_s    = 1'b0;
        dm_wr_s    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_s  = 1'b1;
                mem_iord_s = 1'b1;
                if (bus.mem_ready) begin
                    ir_wr_s = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (is_legal_op(bus.opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_EXECUTE: begin
                if (bus.opcode == OP_BRANCH) begin
                    pc_wr_s  = 1'b1;
                    pc_src_s = bus.branch_taken;
                    state_d  = ST_FETCH;
                end else if ((bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                dm_wr_s   = bus.dec_dm_wr;
                if (bus.mem_ready) begin
                    if (bus.opcode == OP_STORE) begin
                        // A store retires here; PC advances sequentially.
                        pc_wr_s = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                ru_wr_s  = bus.dec_ru_wr;
                pc_wr_s  = 1'b1;
                pc_src_s = (bus.opcode == OP_JAL) || (bus.opcode == OP_JALR);
                state_d  = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State register; reset restarts at FETCH and abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.mem_req  = mem_req_s;
    assign bus.mem_iord = mem_iord_s;
    assign bus.ir_wr    = ir_wr_s;
    assign bus.pc_wr    = pc_wr_s;
    assign bus.pc_src   = pc_src_s;
    assign bus.ru_wr    = ru_wr_s;
    assign bus.dm_wr    = dm_wr_s;
    assign state_o      = state_q;
    assign fault        = (state_q == ST_FAULT);

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instret_cnt_q;

    // Performance counters: live cycles and retirements (one per PC update).
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != ST_FAULT) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (pc_wr_s) begin
                instret_cnt_q <= instret_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
// Each instruction is turned into an expected per-cycle trace (state plus
// strobes, and the mem_ready value to drive) straight from the instruction's
// phase list: fetch with N waits, decode, execute, optional memory phase with
// M waits, optional write-back. The DUT is stepped along the trace and every
// cycle is compared. Performance counters are modelled as totals.
module tb_multicycle_control_fsm;

    localparam int TMO = 4;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_ST  = 7'b0100011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_JR  = 7'b1100111;
    localparam logic [6:0] T_LUI = 7'b0110111;
    localparam logic [6:0] T_AUI = 7'b0010111;

    typedef struct packed {
        logic        rdy;
        logic [10:0] exp;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state_o;
    logic        fault;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    cyc_t        trace[$];
    int          errors  = 0;
    int          checks  = 0;
    int          exp_cyc = 0;
    int          exp_ret = 0;
    logic [6:0]  cur_op;
    logic        cur_bt;
    logic        cur_dru;
    logic        cur_ddm;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .state_o     (state_o),
        .fault       (fault),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic legal_tb(input logic [6:0] op);
        return (op == T_R) || (op == T_I) || (op == T_LD) || (op == T_ST) || (op == T_BR) ||
               (op == T_JAL) || (op == T_JR) || (op == T_LUI) || (op == T_AUI);
    endfunction

    function automatic logic [6:0] op_by_idx(input int k);
        logic [6:0] op;
        case (k)
            0:       op = T_R;
            1:       op = T_I;
            2:       op = T_LD;
            3:       op = T_ST;
            4:       op = T_BR;
            5:       op = T_JAL;
            6:       op = T_JR;
            7:       op = T_LUI;
            default: op = T_AUI;
        endcase
        return op;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected vector layout: {state[2:0], mem_req, mem_iord, ir_wr, pc_wr, pc_src, ru_wr, dm_wr, fault}.
    function automatic logic [10:0] pk(input logic [2:0] st, input logic mreq, input logic iord,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic ruw, input logic dmw, input logic flt);
        return {st, mreq, iord, irw, pcw, pcs, ruw, dmw, flt};
    endfunction

    function automatic logic [10:0] observed();
        return {state_o, bus.mem_req, bus.mem_iord, bus.ir_wr, bus.pc_wr, bus.pc_src,
                bus.ru_wr, bus.dm_wr, fault};
    endfunction

    task automatic push(input logic rdy, input logic [10:0] e);
        cyc_t c;
        c.rdy = rdy;
        c.exp = e;
        trace.push_back(c);
    endtask

    task automatic add_fault(input int n);
        for (int i = 0; i < n; i++) push(rnd(), pk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    // A memory phase: 'waits' cycles without ready (at most TMO before giving up), then completion.
    task automatic mem_phase(input logic [2:0] st, input int waits, input logic iord, input logic dmw,
                             input logic irw_done, input logic pcw_done, output logic ok);
        for (int i = 0; (i < waits) && (i < TMO); i++)
            push(1'b0, pk(st, 1'b1, iord, 1'b0, 1'b0, 1'b0, 1'b0, dmw, 1'b0));
        if (waits >= TMO) begin
            ok = 1'b0;
        end else begin
            push(1'b1, pk(st, 1'b1, iord, irw_done, pcw_done, 1'b0, 1'b0, dmw, 1'b0));
            ok = 1'b1;
        end
    endtask

    task automatic build(input logic [6:0] op, input int fw, input int mw, input logic bt,
                         input logic dru, input logic ddm, input int flen);
        logic ok;
        trace.delete();
        cur_op = op; cur_bt = bt; cur_dru = dru; cur_ddm = ddm;
        mem_phase(3'd0, fw, 1'b1, 1'b0, 1'b1, 1'b0, ok);
        if (!ok) begin add_fault(flen); return; end
        push(rnd(), pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (!legal_tb(op)) begin add_fault(flen); return; end
        if (op == T_BR) begin
            push(rnd(), pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, bt, 1'b0, 1'b0, 1'b0));
            return;
        end
        push(rnd(), pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if ((op == T_LD) || (op == T_ST)) begin
            mem_phase(3'd3, mw, 1'b0, ddm, 1'b0, (op == T_ST), ok);
            if (!ok) begin add_fault(flen); return; end
            if (op == T_ST) return;
        end
        push(rnd(), pk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, ((op == T_JAL) || (op == T_JR)), dru, 1'b0, 1'b0));
    endtask

    // Step the DUT along the trace (up to maxc cycles, negative = all). Entered and left at a negedge.
    task automatic run_trace(input string tag, input int maxc);
        for (int i = 0; (i < trace.size()) && ((maxc < 0) || (i < maxc)); i++) begin
            if (i == 0) begin
                bus.opcode       = cur_op;
                bus.branch_taken = cur_bt;
                bus.dec_ru_wr    = cur_dru;
                bus.dec_dm_wr    = cur_ddm;
            end
            bus.mem_ready = trace[i].rdy;
            #1;
            check_val($sformatf("%s.c%0d", tag, i), 64'(observed()), 64'(trace[i].exp));
`ifdef MULTICYCLE_PERF_CNT_EN
            check_val($sformatf("%s.c%0d.cyc", tag, i), 64'(cycle_cnt), 64'(exp_cyc));
            check_val($sformatf("%s.c%0d.ret", tag, i), 64'(instret_cnt), 64'(exp_ret));
`else
            check_val($sformatf("%s.c%0d.cnt", tag, i), 64'({cycle_cnt, instret_cnt}), 64'd0);
`endif
            if (trace[i].exp[10:8] != 3'd7) exp_cyc++;
            if (trace[i].exp[4]) exp_ret++;
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input int fw, input int mw,
                             input logic bt, input logic dru, input logic ddm, input int flen);
        build(op, fw, mw, bt, dru, ddm, flen);
        run_trace(tag, -1);
    endtask

    // Synchronous reset pulse for one edge, then check the FETCH reset state.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.mem_ready = rnd();
        @(negedge clk);
        rst = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        bus.mem_ready = 1'b0;
        #1;
        check_val({tag, ".state"}, 64'(observed()), 64'(pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        check_val({tag, ".cnt"}, 64'({cycle_cnt, instret_cnt}), 64'd0);
    endtask

    initial begin
        logic [6:0] op;
        int         r;
        rst = 1'b1;
        bus.opcode = 7'd0; bus.dec_ru_wr = 1'b0; bus.dec_dm_wr = 1'b0;
        bus.branch_taken = 1'b0; bus.mem_ready = 1'b0;
        cur_op = 7'd0; cur_bt = 1'b0; cur_dru = 1'b0; cur_ddm = 1'b0;
        @(negedge clk);
        do_reset("por");

        // Directed cases.
        run_instr("rtype", T_R, 0, 0, 1'b0, 1'b1, 1'b1, 0);
        run_instr("load_wait", T_LD, 0, 3, 1'b0, 1'b1, 1'b0, 0);
        run_instr("branch", T_BR, 0, 0, 1'b1, 1'b1, 1'b1, 0);
        run_instr("jal", T_JAL, 1, 0, 1'b0, 1'b1, 1'b0, 0);
        run_instr("store", T_ST, 2, 1, 1'b0, 1'b1, 1'b1, 0);
        run_instr("illegal", 7'b1111111, 0, 0, 1'b0, 1'b1, 1'b1, 20);
        do_reset("rst_after_illegal");
        run_instr("fetch_timeout", T_R, TMO, 0, 1'b0, 1'b1, 1'b0, 3);
        do_reset("rst_after_tmo");
        run_instr("fetch_ready_last", T_R, TMO - 1, 0, 1'b0, 1'b1, 1'b0, 0);
        run_instr("mem_timeout", T_LD, 0, TMO, 1'b0, 1'b1, 1'b0, 3);
        do_reset("rst_after_mtmo");

        // Ten back-to-back zero-wait R-type instructions from reset.
        for (int k = 0; k < 10; k++) run_instr("perf", T_R, 0, 0, 1'b0, 1'b1, 1'b0, 0);
`ifdef MULTICYCLE_PERF_CNT_EN
        check_val("perf.instret", 64'(instret_cnt), 64'd10);
        check_val("perf.cycles", 64'(cycle_cnt), 64'd40);
`else
        check_val("perf.tied0", 64'({cycle_cnt, instret_cnt}), 64'd0);
`endif

        // Store abandoned by reset while waiting in MEM.
        build(T_ST, 0, 3, 1'b0, 1'b0, 1'b1, 0);
        run_trace("store_abort", 5);
        do_reset("rst_mid_store");
        run_instr("store_redo", T_ST, 0, 2, 1'b0, 1'b0, 1'b1, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                op = 7'($urandom_range(0, 127));
                while (legal_tb(op)) op = 7'($urandom_range(0, 127));
                run_instr($sformatf("rnd%0d.ill", n), op, $urandom_range(0, 3), 0, rnd(), rnd(), rnd(),
                          $urandom_range(1, 4));
                do_reset($sformatf("rnd%0d.rst", n));
            end else if (r == 1) begin
                op = rnd() ? T_LD : T_ST;
                if (rnd()) begin
                    run_instr($sformatf("rnd%0d.ftmo", n), op, TMO + $urandom_range(0, 2), 0,
                              rnd(), rnd(), rnd(), 2);
                end else begin
                    run_instr($sformatf("rnd%0d.mtmo", n), op, $urandom_range(0, 3),
                              TMO + $urandom_range(0, 2), rnd(), rnd(), rnd(), 2);
                end
                do_reset($sformatf("rnd%0d.rst", n));
            end else begin
                op = op_by_idx($urandom_range(0, 8));
                run_instr($sformatf("rnd%0d.op%0h", n, op), op, $urandom_range(0, 3),
                          $urandom_range(0, 3), rnd(), rnd(), rnd(), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
